// File: rtl/ldpc_enc_core_if.sv
// Handshake bundle for ldpc_enc_core: message block input stream and codeword output.
// The encoder connects through the slave modport, its upstream/downstream through master.
interface ldpc_enc_core_if #(
    parameter int R = 24,
    parameter int D = 96
);
    logic           msg_valid;
    logic           msg_ready;
    logic [D-1:0]   msg_data;
    logic           cw_valid;
    logic           cw_ready;
    logic [R*D-1:0] cw;
    logic           synd_err;

    modport slave (
        input  msg_valid, msg_data, cw_ready,
        output msg_ready, cw_valid, cw, synd_err
    );

    modport master (
        output msg_valid, msg_data, cw_ready,
        input  msg_ready, cw_valid, cw, synd_err
    );
endinterface

// File: rtl/ldpc_enc_core.sv
// Systematic QC-LDPC encoder with dual-diagonal parity, one parity block per cycle.
// Optional macro LDPC_ENC_CHECK_EN adds a CHK state that computes the last-row syndrome.
module ldpc_enc_core #(
    parameter int mtx_w = 8,
    parameter int R     = 24,
    parameter int C     = 12,
    parameter int D     = 96
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [C*R*mtx_w-1:0] mtx,
    ldpc_enc_core_if.slave       bus
);
    localparam int KB   = R - C;
    localparam int CNTW = $clog2(R + 1);
    localparam int PW   = $clog2(C);

`ifdef LDPC_ENC_CHECK_EN
    typedef enum logic [2:0] {ACC, P0, PAR, CHK, OUT} state_t;
`else
    typedef enum logic [1:0] {ACC, P0, PAR, OUT} state_t;
`endif

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q;
    logic [PW-1:0]   pidx_q;
    logic [PW-1:0]   k_row;
    logic [D-1:0]    lambda_q [C];
    logic [R*D-1:0]  cw_q;
    logic [D-1:0]    p0_q;
    logic [D-1:0]    p_prev_q;
    logic [D-1:0]    p0_c;
    logic [D-1:0]    p_new;
    logic [mtx_w-1:0] x_shift;
    logic            rdy;
    logic            beat;
    logic            hs;
    logic            k_found;
`ifdef LDPC_ENC_CHECK_EN
    logic            synd_q;
`endif

    function automatic logic is_null(input logic [mtx_w-1:0] s);
        return (s == '1) || (32'(s) >= 32'(D));
    endfunction

    // (P^s b)[r] = b[(r+s) mod D]; null entries give the zero block
    function automatic logic [D-1:0] circ(input logic [D-1:0] b, input logic [mtx_w-1:0] s);
        logic [D-1:0] r;
        r = '0;
        if (!is_null(s)) begin
            for (int unsigned n = 0; n < D; n++) begin
                r[n] = b[(n + 32'(s)) % D];
            end
        end
        return r;
    endfunction

    assign x_shift = mtx[KB*mtx_w +: mtx_w];

    always_comb begin
        k_row   = '0;
        k_found = 1'b0;
        for (int unsigned i = 1; i <= C - 2; i++) begin
            if (!k_found && !is_null(mtx[(i*R + KB)*mtx_w +: mtx_w])) begin
                k_row   = PW'(i);
                k_found = 1'b1;
            end
        end
    end

    always_comb begin
        p0_c = '0;
        for (int unsigned i = 0; i < C; i++) begin
            p0_c = p0_c ^ lambda_q[i];
        end
    end

    // p_prev_q is seeded with P^x p0 in P0, so p1 uses the same recurrence as later blocks
    always_comb begin
        p_new = p_prev_q ^ lambda_q[pidx_q] ^ ((pidx_q == k_row) ? p0_q : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        beat    = 1'b0;
        hs      = 1'b0;
        case (state_q)
            ACC: begin
                rdy  = !rst;
                beat = rdy && bus.msg_valid;
                if (beat && cnt_q == CNTW'(KB - 1)) begin
                    state_d = P0;
                end
            end
            P0: state_d = PAR;
            PAR: begin
                if (pidx_q == PW'(C - 2)) begin
`ifdef LDPC_ENC_CHECK_EN
                    state_d = CHK;
`else
                    state_d = OUT;
`endif
                end
            end
`ifdef LDPC_ENC_CHECK_EN
            CHK: state_d = OUT;
`endif
            OUT: begin
                hs = bus.cw_ready;
                if (hs) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < C; i++) begin
                lambda_q[i] <= '0;
            end
            cnt_q    <= '0;
            pidx_q   <= '0;
            cw_q     <= '0;
            p0_q     <= '0;
            p_prev_q <= '0;
`ifdef LDPC_ENC_CHECK_EN
            synd_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ACC: begin
                    if (beat) begin
                        for (int unsigned i = 0; i < C; i++) begin
                            lambda_q[i] <= lambda_q[i]
                                ^ circ(bus.msg_data, mtx[(i*R + 32'(cnt_q))*mtx_w +: mtx_w]);
                        end
                        cw_q[int'(cnt_q)*D +: D] <= bus.msg_data;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                P0: begin
                    p0_q               <= p0_c;
                    p_prev_q           <= circ(p0_c, x_shift);
                    cw_q[KB*D +: D]    <= p0_c;
                    pidx_q             <= '0;
                end
                PAR: begin
                    cw_q[(KB + 1 + int'(pidx_q))*D +: D] <= p_new;
                    p_prev_q <= p_new;
                    pidx_q   <= pidx_q + 1'b1;
                end
`ifdef LDPC_ENC_CHECK_EN
                CHK: begin
                    synd_q <= |(lambda_q[C-1]
                                ^ circ(p0_q, mtx[((C-1)*R + KB)*mtx_w +: mtx_w])
                                ^ p_prev_q);
                end
`endif
                OUT: begin
                    if (hs) begin
                        for (int unsigned i = 0; i < C; i++) begin
                            lambda_q[i] <= '0;
                        end
                        cnt_q  <= '0;
                        pidx_q <= '0;
`ifdef LDPC_ENC_CHECK_EN
                        synd_q <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.msg_ready = rdy;
    assign bus.cw_valid  = (state_q == OUT);
    assign bus.cw        = cw_q;
`ifdef LDPC_ENC_CHECK_EN
    assign bus.synd_err  = synd_q;
`else
    assign bus.synd_err  = 1'b0;
`endif
endmodule

// File: tb/tb_ldpc_enc_core.sv
// Directed self-checking bench for ldpc_enc_core with R=6, C=3, D=4.
// Expected codewords are hand-derived from the small test matrix.
module tb_ldpc_enc_core;
    localparam int MW = 8;
    localparam int R  = 6;
    localparam int C  = 3;
    localparam int D  = 4;
`ifdef LDPC_ENC_CHECK_EN
    localparam int LAT = C + 2;
`else
    localparam int LAT = C + 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [C*R*MW-1:0] mtx;
    int                checks = 0;
    int                failures = 0;

    ldpc_enc_core_if #(.R(R), .D(D)) bus ();

    ldpc_enc_core #(.mtx_w(MW), .R(R), .C(C), .D(D)) dut (
        .clk (clk),
        .rst (rst),
        .mtx (mtx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int i, input int j, input logic [7:0] v);
        mtx[(i*R + j)*MW +: MW] = v;
    endtask

    task automatic base_mtx;
        mtx = '1;
        set_entry(0, 0, 8'd0);
        set_entry(0, 3, 8'd1);
        set_entry(1, 3, 8'd0);
        set_entry(2, 3, 8'd1);
        set_entry(0, 4, 8'd0);
        set_entry(1, 4, 8'd0);
        set_entry(1, 5, 8'd0);
        set_entry(2, 5, 8'd0);
    endtask

    task automatic send3(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2);
        logic [3:0] blk [3];
        blk[0] = b0; blk[1] = b1; blk[2] = b2;
        for (int i = 0; i < 3; i++) begin
            bus.msg_valid = 1'b1;
            bus.msg_data  = blk[i];
            tick;
        end
        bus.msg_valid = 1'b0;
        bus.msg_data  = '0;
    endtask

    // n counts edges from the last accepted beat (that edge is n=1)
    task automatic wait_cw(output int n);
        n = 1;
        while (bus.cw_valid !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
    endtask

    task automatic handshake;
        bus.cw_ready = 1'b1;
        tick;
        bus.cw_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if (bus.msg_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%b exp=0", bus.msg_ready);
        end
        checks++;
        if (bus.cw_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", bus.cw_valid);
        end
        checks++;
        if (bus.cw !== 24'h0) begin
            failures++; $display("FAIL reset_cw got=%h exp=000000", bus.cw);
        end
        checks++;
        if (bus.synd_err !== 1'b0) begin
            failures++; $display("FAIL reset_synd got=%b exp=0", bus.synd_err);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (bus.msg_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready_after got=%b exp=1", bus.msg_ready);
        end
    endtask

    task automatic test_basic;
        int n;
        base_mtx;
        send3(4'b0001, 4'b0000, 4'b0000);
        wait_cw(n);
        checks++;
        if (n !== LAT) begin
            failures++; $display("FAIL basic_latency got=%0d exp=%0d", n, LAT);
        end
        checks++;
        if (bus.cw !== 24'h891001) begin
            failures++; $display("FAIL basic_cw got=%h exp=891001", bus.cw);
        end
        checks++;
        if (bus.synd_err !== 1'b0) begin
            failures++; $display("FAIL basic_synd got=%b exp=0", bus.synd_err);
        end
        handshake;
        checks++;
        if (bus.cw_valid !== 1'b0 || bus.msg_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_post_hs got valid=%b ready=%b exp valid=0 ready=1", bus.cw_valid, bus.msg_ready);
        end
    endtask

    task automatic test_patterns;
        int n;
        base_mtx;
        send3(4'b0110, 4'b1010, 4'b1111);
        wait_cw(n);
        checks++;
        if (bus.cw !== 24'h356FA6) begin
            failures++; $display("FAIL pattern_a_cw got=%h exp=356fa6", bus.cw);
        end
        handshake;
        // Real shifts on cols 1,2; entries equal to D and 2^w-2 must act as null
        set_entry(1, 1, 8'd3);
        set_entry(2, 2, 8'd2);
        set_entry(1, 0, 8'd4);
        set_entry(2, 0, 8'd254);
        send3(4'b0001, 4'b0001, 4'b0001);
        wait_cw(n);
        checks++;
        if (n !== LAT) begin
            failures++; $display("FAIL pattern_b_latency got=%0d exp=%0d", n, LAT);
        end
        checks++;
        if (bus.cw !== 24'hFA7111) begin
            failures++; $display("FAIL pattern_b_cw got=%h exp=fa7111", bus.cw);
        end
        checks++;
        if (bus.synd_err !== 1'b0) begin
            failures++; $display("FAIL pattern_b_synd got=%b exp=0", bus.synd_err);
        end
        handshake;
        base_mtx;
    endtask

    task automatic test_zero;
        int n;
        base_mtx;
        send3(4'b0000, 4'b0000, 4'b0000);
        wait_cw(n);
        checks++;
        if (n !== LAT) begin
            failures++; $display("FAIL zero_latency got=%0d exp=%0d", n, LAT);
        end
        checks++;
        if (bus.cw !== 24'h0) begin
            failures++; $display("FAIL zero_cw got=%h exp=000000", bus.cw);
        end
        handshake;
    endtask

    task automatic test_back_to_back;
        int n;
        int bad;
        base_mtx;
        send3(4'b0001, 4'b0000, 4'b0000);
        wait_cw(n);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.msg_valid = 1'b1;
            bus.msg_data  = 4'hF;
            tick;
            checks++;
            if (bus.cw_valid !== 1'b1 || bus.cw !== 24'h891001 || bus.msg_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d got valid=%b cw=%h ready=%b exp valid=1 cw=891001 ready=0",
                         i, bus.cw_valid, bus.cw, bus.msg_ready);
            end
        end
        bus.msg_valid = 1'b0;
        bus.msg_data  = '0;
        handshake;
        checks++;
        if (bus.msg_ready !== 1'b1 || bus.cw_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_release got ready=%b valid=%b exp ready=1 valid=0", bus.msg_ready, bus.cw_valid);
        end
        send3(4'b0110, 4'b1010, 4'b1111);
        wait_cw(n);
        checks++;
        if (bus.cw !== 24'h356FA6) begin
            failures++; $display("FAIL hold_next_cw got=%h exp=356fa6", bus.cw);
        end
        handshake;
    endtask

    task automatic test_rst_mid;
        int n;
        base_mtx;
        bus.msg_valid = 1'b1;
        bus.msg_data  = 4'hF;
        tick;
        tick;
        bus.msg_valid = 1'b0;
        rst = 1'b1;
        tick;
        checks++;
        if (bus.msg_ready !== 1'b0 || bus.cw_valid !== 1'b0 || bus.cw !== 24'h0 || bus.synd_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs got ready=%b valid=%b cw=%h synd=%b exp all zero",
                     bus.msg_ready, bus.cw_valid, bus.cw, bus.synd_err);
        end
        rst = 1'b0;
        tick;
        send3(4'b0001, 4'b0000, 4'b0000);
        wait_cw(n);
        checks++;
        if (n !== LAT) begin
            failures++; $display("FAIL rst_mid_latency got=%0d exp=%0d", n, LAT);
        end
        checks++;
        if (bus.cw !== 24'h891001) begin
            failures++; $display("FAIL rst_mid_cw got=%h exp=891001", bus.cw);
        end
        handshake;
    endtask

    task automatic test_gaps;
        int n;
        logic       vseq [6];
        logic [3:0] dseq [6];
        vseq[0] = 1; vseq[1] = 0; vseq[2] = 0; vseq[3] = 1; vseq[4] = 0; vseq[5] = 1;
        dseq[0] = 4'h1; dseq[1] = 4'hF; dseq[2] = 4'hF; dseq[3] = 4'h0; dseq[4] = 4'hF; dseq[5] = 4'h0;
        base_mtx;
        for (int i = 0; i < 6; i++) begin
            bus.msg_valid = vseq[i];
            bus.msg_data  = dseq[i];
            tick;
        end
        bus.msg_valid = 1'b0;
        bus.msg_data  = '0;
        wait_cw(n);
        checks++;
        if (n !== LAT) begin
            failures++; $display("FAIL gaps_latency got=%0d exp=%0d", n, LAT);
        end
        checks++;
        if (bus.cw !== 24'h891001) begin
            failures++; $display("FAIL gaps_cw got=%h exp=891001", bus.cw);
        end
        handshake;
    endtask

`ifdef LDPC_ENC_CHECK_EN
    task automatic test_synd;
        int n;
        base_mtx;
        set_entry(2, 3, 8'd2);
        send3(4'b0001, 4'b0000, 4'b0000);
        wait_cw(n);
        checks++;
        if (bus.cw_valid !== 1'b1 || bus.synd_err !== 1'b1) begin
            failures++;
            $display("FAIL synd_flag got valid=%b synd=%b exp valid=1 synd=1", bus.cw_valid, bus.synd_err);
        end
        checks++;
        if (bus.cw !== 24'h891001) begin
            failures++; $display("FAIL synd_cw got=%h exp=891001", bus.cw);
        end
        handshake;
        checks++;
        if (bus.synd_err !== 1'b0) begin
            failures++; $display("FAIL synd_clear got=%b exp=0", bus.synd_err);
        end
        base_mtx;
    endtask
`endif

    initial begin
        bus.msg_valid = 1'b0;
        bus.msg_data  = '0;
        bus.cw_ready  = 1'b0;
        base_mtx;
        test_reset;
        test_basic;
        test_patterns;
        test_zero;
        test_back_to_back;
        test_rst_mid;
        test_gaps;
`ifdef LDPC_ENC_CHECK_EN
        test_synd;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
